// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encoding and mode constants for the GCD engine
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_BIN = 1'b1;

endpackage

// File: rtl/gcd_step.sv
// rtl/gcd_step.sv - one combinational reduction step, subtractive or binary
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic             k_inc,
  output logic             term
);

  logic             a_ge_b;
  logic             a_even;
  logic             b_even;
  logic [WIDTH-1:0] a_minus_b;
  logic [WIDTH-1:0] b_minus_a;

  assign term      = (a == '0) || (b == '0);
  assign a_ge_b    = (a >= b);
  assign a_even    = ~a[0];
  assign b_even    = ~b[0];
  assign a_minus_b = a - b;
  assign b_minus_a = b - a;

  // Subtractive mode and the both-odd binary case share the same compare-subtract path
  always_comb begin
    a_nxt = a;
    b_nxt = b;
    k_inc = 1'b0;
    if (!term) begin
      if (mode == MODE_SUB || (!a_even && !b_even)) begin
        if (a_ge_b) a_nxt = a_minus_b;
        else        b_nxt = b_minus_a;
      end else if (a_even && b_even) begin
        a_nxt = a >> 1;
        b_nxt = b >> 1;
        k_inc = 1'b1;
      end else if (a_even) begin
        a_nxt = a >> 1;
      end else begin
        b_nxt = b >> 1;
      end
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - iterative GCD engine with valid/ready handshakes and step counting
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ITER_W = WIDTH + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  input  logic              mode_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  gcd_out,
  output logic [ITER_W-1:0] iter_out,
  output logic              zero_out,
  output logic              busy
);

  localparam int KW = $clog2(WIDTH) + 1;

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [KW-1:0]     k_q;
  logic [ITER_W-1:0] count_q;
  logic              mode_q;

  logic [WIDTH-1:0]  a_nxt;
  logic [WIDTH-1:0]  b_nxt;
  logic              k_inc;
  logic              term;
  logic [WIDTH-1:0]  max_ab;
  logic [ITER_W-1:0] count_inc;

  gcd_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a     (a_q),
    .b     (b_q),
    .mode  (mode_q),
    .a_nxt (a_nxt),
    .b_nxt (b_nxt),
    .k_inc (k_inc),
    .term  (term)
  );

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign max_ab    = (a_q >= b_q) ? a_q : b_q;
  // Step counter sticks at all-ones rather than wrapping
  assign count_inc = (&count_q) ? count_q : count_q + ITER_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      k_q       <= '0;
      count_q   <= '0;
      mode_q    <= MODE_SUB;
      gcd_out   <= '0;
      iter_out  <= '0;
      zero_out  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q       <= a_in;
            b_q       <= b_in;
            mode_q    <= mode_in;
            k_q       <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (term) begin
            // k only moves in binary mode, so the shift is a no-op for subtractive
            gcd_out   <= max_ab << k_q;
            iter_out  <= count_q;
            zero_out  <= (a_q == '0) && (b_q == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            count_q <= count_inc;
            if (k_inc) k_q <= k_q + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// tb/tb_gcd_engine.sv - self-checking bench for gcd_engine against an arithmetic reference
module tb_gcd_engine;

  localparam int WIDTH  = 8;
  localparam int ITER_W = WIDTH + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a_in;
  logic [WIDTH-1:0]  b_in;
  logic              mode_in;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  gcd_out;
  logic [ITER_W-1:0] iter_out;
  logic              zero_out;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int g;
    int it;
    int z;
  } exp_t;

  exp_t exp_q[$];

  gcd_engine #(
    .WIDTH  (WIDTH),
    .ITER_W (ITER_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .mode_in   (mode_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gcd_out   (gcd_out),
    .iter_out  (iter_out),
    .zero_out  (zero_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // gcd by modulo Euclid; step counts from the quotient sum (subtractive) or a rule walk (binary)
  function automatic exp_t ref_model(input int a, input int b, input bit m);
    exp_t r;
    int x, y, t, it;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    r.g = x;
    r.z = (a == 0 && b == 0) ? 1 : 0;
    it = 0;
    if (a != 0 && b != 0) begin
      if (!m) begin
        x = (a >= b) ? a : b;
        y = (a >= b) ? b : a;
        while (y != 0) begin it += x / y; t = x % y; x = y; y = t; end
      end else begin
        x = a; y = b;
        while (x != 0 && y != 0) begin
          if (x % 2 == 0 && y % 2 == 0) begin x /= 2; y /= 2; end
          else if (x % 2 == 0) x /= 2;
          else if (y % 2 == 0) y /= 2;
          else if (x >= y) x -= y;
          else y -= x;
          it++;
        end
      end
    end
    r.it = (it > (1 << ITER_W) - 1) ? (1 << ITER_W) - 1 : it;
    return r;
  endfunction

  task automatic run_op(input int a, input int b, input bit m,
                        output int g, output int it, output int z, output int lat);
    int guard;
    out_ready = 1'b0;
    a_in = WIDTH'(a); b_in = WIDTH'(b); mode_in = m; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 600) begin @(negedge clk); lat++; end
    check("op_out_valid", out_valid, 1);
    g = gcd_out; it = iter_out; z = zero_out;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  int d_a[9]  = '{30, 30, 12, 12, 0, 0, 255, 7, 0};
  int d_b[9]  = '{10, 10, 18, 18, 0, 0, 1,   0, 9};
  int d_m[9]  = '{0,  1,  0,  1,  0, 1, 0,   0, 1};
  int d_g[9]  = '{10, 10, 6,  6,  0, 0, 1,   7, 9};
  int d_it[9] = '{3,  4,  3,  5,  0, 0, 255, 0, 0};
  int d_z[9]  = '{0,  0,  0,  0,  1, 1, 0,   0, 0};

  initial begin
    int g, it, z, lat;
    exp_t e;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; mode_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gcd", gcd_out, 0);
    check("rst_iter", iter_out, 0);
    check("rst_zero", zero_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 9; i++) begin
      run_op(d_a[i], d_b[i], d_m[i][0], g, it, z, lat);
      check($sformatf("dir%0d_gcd", i), g, d_g[i]);
      check($sformatf("dir%0d_iter", i), it, d_it[i]);
      check($sformatf("dir%0d_zero", i), z, d_z[i]);
      check($sformatf("dir%0d_latency", i), lat, d_it[i] + 2);
    end

    // async reset in the middle of a long subtractive run
    run_op(30, 10, 1'b0, g, it, z, lat);
    a_in = 8'd200; b_in = 8'd3; mode_in = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_gcd", gcd_out, 0);
    check("mid_rst_iter", iter_out, 0);
    check("mid_rst_zero", zero_out, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_in_ready", in_ready, 1);
    check("mid_out_valid", out_valid, 0);
    run_op(12, 18, 1'b1, g, it, z, lat);
    check("post_rst_gcd", g, 6);
    check("post_rst_iter", it, 5);

    // consumer stalls in DONE while new operands are offered
    a_in = 8'd12; b_in = 8'd18; mode_in = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    for (int i = 0; i < 10; i++) begin
      a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); mode_in = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_gcd", gcd_out, 6);
      check("hold_iter", iter_out, 3);
      check("hold_zero", zero_out, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("taken_out_valid", out_valid, 0);
    check("taken_in_ready", in_ready, 1);
    check("taken_busy", busy, 0);
    check("taken_gcd_kept", gcd_out, 6);
    check("taken_iter_kept", iter_out, 3);

    // random back-to-back traffic with a randomly stalling consumer
    fork
      begin
        int guard;
        for (int i = 0; i < 1000; i++) begin
          int ra, rb;
          bit rm;
          ra = ($urandom % 8 == 0) ? 0 : int'($urandom % 256);
          rb = ($urandom % 8 == 0) ? 0 : int'($urandom % 256);
          rm = 1'($urandom);
          a_in = WIDTH'(ra); b_in = WIDTH'(rb); mode_in = rm; in_valid = 1'b1;
          guard = 0;
          while (!in_ready && guard < 2000) begin @(negedge clk); guard++; end
          if (!in_ready) begin
            check("rand_accept_timeout", in_ready, 1);
            break;
          end
          exp_q.push_back(ref_model(ra, rb, rm));
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        int got, cyc;
        got = 0; cyc = 0;
        while (got < 1000 && cyc < 70000) begin
          out_ready = ($urandom % 4) != 0;
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              check("rand_unexpected_result", 0, 1);
            end else begin
              e = exp_q.pop_front();
              check("rand_gcd", gcd_out, e.g);
              check("rand_iter", iter_out, e.it);
              check("rand_zero", zero_out, e.z);
            end
            got++;
          end
          @(negedge clk);
          cyc++;
        end
        out_ready = 1'b0;
        check("rand_results_seen", got, 1000);
      end
    join

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
